// File: rtl/prince_pkg.sv
// Shared PRINCE definitions: cipher constants plus the AXI-Stream master's
// state encoding, beat counts and status bit positions.
package prince_pkg;

  localparam logic [63:0] PRINCE_ALPHA = 64'hC0AC29B7C97C50DD;

  localparam logic [63:0] PRINCE_RC [12] = '{
    64'h0000000000000000, 64'h13198A2E03707344, 64'hA4093822299F31D0,
    64'h082EFA98EC4E6C89, 64'h452821E638D01377, 64'hBE5466CF34E90C6C,
    64'h7EF84F78FD955CB1, 64'h85840851F1AC43AA, 64'hC882D32F25323C54,
    64'h64A51195E0E3610D, 64'hD3B5A399CA0C2399, 64'hC0AC29B7C97C50DD
  };

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  localparam int unsigned OUT_BEATS    = 6;
  localparam int unsigned IN_BEATS     = 2;
  localparam int unsigned ST_TLAST_ERR = 0;
  localparam int unsigned ST_TIMEOUT   = 1;

endpackage

// File: rtl/prince_axis_master.sv
// Sends plaintext+key to a PRINCE core as six 32-bit AXIS beats and collects
// the two-beat ciphertext response, with optional response timeout.
module prince_axis_master
  import prince_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         start,
  input  logic [63:0]  plaintext,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [63:0]  ciphertext,
  output logic [1:0]   status,
  output logic [31:0]  M_AXIS_TDATA,
  output logic         M_AXIS_TVALID,
  output logic         M_AXIS_TLAST,
  input  logic         M_AXIS_TREADY,
  input  logic [31:0]  S_AXIS_TDATA,
  input  logic         S_AXIS_TVALID,
  input  logic         S_AXIS_TLAST,
  output logic         S_AXIS_TREADY
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t         state;
  logic [2:0]     beat;
  logic [TW-1:0]  tcnt;
  logic [TW-1:0]  tcnt_inc;
  logic [159:0]   pend;
  logic [31:0]    ct_hi;
  logic           tlast_err;
  logic           m_fire;
  logic           s_fire;
  logic           timed_out;

  assign m_fire    = M_AXIS_TVALID & M_AXIS_TREADY;
  assign s_fire    = S_AXIS_TVALID & S_AXIS_TREADY;
  assign tcnt_inc  = tcnt + TW'(1);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (tcnt_inc == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      beat          <= '0;
      tcnt          <= '0;
      pend          <= '0;
      ct_hi         <= '0;
      tlast_err     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ciphertext    <= '0;
      status        <= '0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      S_AXIS_TREADY <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= SEND;
            beat          <= '0;
            busy          <= 1'b1;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TDATA  <= plaintext[63:32];
            pend          <= {plaintext[31:0], key};
          end
        end
        SEND: begin
          if (m_fire) begin
            if (beat == 3'(OUT_BEATS - 1)) begin
              state         <= RECV;
              beat          <= '0;
              tcnt          <= '0;
              tlast_err     <= 1'b0;
              M_AXIS_TVALID <= 1'b0;
              M_AXIS_TLAST  <= 1'b0;
              M_AXIS_TDATA  <= '0;
              S_AXIS_TREADY <= 1'b1;
            end else begin
              // pend is consumed MSB-first so the next word is always on top
              beat         <= beat + 3'd1;
              M_AXIS_TDATA <= pend[159:128];
              pend         <= {pend[127:0], 32'h0};
              M_AXIS_TLAST <= (beat == 3'(OUT_BEATS - 2));
            end
          end
        end
        RECV: begin
          if (s_fire) begin
            tcnt <= '0;
            if (beat == 3'(IN_BEATS - 1)) begin
              state                  <= DONE;
              beat                   <= '0;
              busy                   <= 1'b0;
              done                   <= 1'b1;
              S_AXIS_TREADY          <= 1'b0;
              ciphertext             <= {ct_hi, S_AXIS_TDATA};
              status[ST_TLAST_ERR]   <= tlast_err | ~S_AXIS_TLAST;
              status[ST_TIMEOUT]     <= 1'b0;
            end else begin
              beat      <= beat + 3'd1;
              ct_hi     <= S_AXIS_TDATA;
              tlast_err <= S_AXIS_TLAST;
            end
          end else if (timed_out) begin
            // Only beats actually received overwrite the held ciphertext
            state                <= DONE;
            beat                 <= '0;
            tcnt                 <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b1;
            S_AXIS_TREADY        <= 1'b0;
            if (beat != '0) ciphertext[63:32] <= ct_hi;
            status[ST_TLAST_ERR] <= tlast_err;
            status[ST_TIMEOUT]   <= 1'b1;
          end else if (TIMEOUT_CYCLES != 0) begin
            tcnt <= tcnt_inc;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prince_axis_master.sv
// Randomized bench for prince_axis_master with a word-list reference model of
// the request stream and a scripted responder on the response stream.
module tb_prince_axis_master;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic         start;
  logic [63:0]  plaintext;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [63:0]  ciphertext;
  logic [1:0]   status;
  logic [31:0]  M_AXIS_TDATA;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TLAST;
  logic         M_AXIS_TREADY;
  logic [31:0]  S_AXIS_TDATA;
  logic         S_AXIS_TVALID;
  logic         S_AXIS_TLAST;
  logic         S_AXIS_TREADY;

  always #5 ACLK = ~ACLK;

  prince_axis_master #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .plaintext(plaintext), .key(key),
    .busy(busy), .done(done), .ciphertext(ciphertext), .status(status),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [63:0] model_ct = '0;

  logic [31:0] obs_data[$];
  logic        obs_last[$];
  int          done_cyc, done_cnt, recv_cyc, last_m_cyc, last_s_cyc, viol, busy_bad, busy_gap;
  logic [63:0] done_ct;
  logic [1:0]  done_st;

  // Request word i of a transaction: the 192-bit {pt,key} split MSB-first.
  function automatic logic [31:0] exp_word(input logic [63:0] pt, input logic [127:0] k, input int i);
    logic [191:0] f;
    f = {pt, k} >> (32 * (5 - i));
    return f[31:0];
  endfunction

  function automatic logic [5:0] last_mask();
    logic [5:0] m = '0;
    for (int i = 0; i < obs_last.size() && i < 6; i++) m[i] = obs_last[i];
    return m;
  endfunction

  // Runs one transaction from a negedge; cycle 0 carries start. Records observations only.
  task automatic run_txn(input logic [63:0] pt, input logic [127:0] k, input bit rnd_ready,
                         input int n_resp, input logic [31:0] r0, input logic [31:0] r1,
                         input logic l0, input logic l1, input int repulse);
    int   n_s;
    bit   prev_stall;
    logic [31:0] prev_d;
    logic prev_l;
    obs_data.delete(); obs_last.delete();
    done_cyc = -1; done_cnt = 0; recv_cyc = -1; last_m_cyc = -1; last_s_cyc = -1;
    viol = 0; busy_bad = 0; busy_gap = 0; n_s = 0; prev_stall = 0; prev_d = '0; prev_l = 1'b0;
    @(negedge ACLK);
    start = 1'b1; plaintext = pt; key = k;
    M_AXIS_TREADY = 1'b1; S_AXIS_TVALID = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge ACLK);
      start = (repulse != 0) && (c == repulse || c == repulse + 4 || c == repulse + 6 || c == repulse + 7);
      if (start) begin plaintext = ~pt; key = ~k; end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; done_ct = ciphertext; done_st = status; end
        if (busy) busy_bad++;
      end else if (done_cyc < 0 && !busy) busy_gap++;
      if (S_AXIS_TREADY && recv_cyc < 0) recv_cyc = c;
      M_AXIS_TREADY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      S_AXIS_TVALID = (n_s < n_resp);
      S_AXIS_TDATA  = (n_s == 0) ? r0 : r1;
      S_AXIS_TLAST  = (n_s == 0) ? l0 : l1;
      #4;
      if (prev_stall && (!M_AXIS_TVALID || M_AXIS_TDATA !== prev_d || M_AXIS_TLAST !== prev_l)) viol++;
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_d = M_AXIS_TDATA; prev_l = M_AXIS_TLAST;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        obs_data.push_back(M_AXIS_TDATA); obs_last.push_back(M_AXIS_TLAST); last_m_cyc = c;
      end
      if (S_AXIS_TVALID && S_AXIS_TREADY) begin n_s++; last_s_cyc = c; end
      if (done_cyc > 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; start = 1'b1;
    repeat (3) @(negedge ACLK);
    total++;
    if ({M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY, busy, done} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY, busy, done});
    end
    total++;
    if (M_AXIS_TDATA !== 32'h0) begin bad++; $display("FAIL reset_tdata: got %h want 0", M_AXIS_TDATA); end
    total++;
    if (ciphertext !== 64'h0) begin bad++; $display("FAIL reset_ct: got %h want 0", ciphertext); end
    total++;
    if (status !== 2'b00) begin bad++; $display("FAIL reset_status: got %b want 00", status); end
    start = 1'b0; ARESET = 1'b0;
  endtask

  task automatic test_basic();
    run_txn(64'h0, 128'h0, 1'b0, 2, 32'h818665AA, 32'h0D02DFDA, 1'b0, 1'b1, 0);
    model_ct = 64'h818665AA0D02DFDA;
    total++;
    if (done_cyc !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", done_cyc); end
    total++;
    if (done_ct !== model_ct) begin bad++; $display("FAIL basic_ct: got %h want %h", done_ct, model_ct); end
    total++;
    if (done_st !== 2'b00) begin bad++; $display("FAIL basic_status: got %b want 00", done_st); end
    total++;
    if (recv_cyc !== 7) begin bad++; $display("FAIL basic_recv_entry: got %0d want 7", recv_cyc); end
    total++;
    if (busy_bad !== 0 || busy_gap !== 0) begin
      bad++; $display("FAIL basic_busy: got bad=%0d gap=%0d want 0/0", busy_bad, busy_gap);
    end
  endtask

  task automatic test_random_ready();
    for (int t = 0; t < 4; t++) begin
      logic [63:0]  pt;
      logic [127:0] k;
      logic [31:0]  r0, r1;
      pt = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
      r0 = $urandom; r1 = $urandom;
      run_txn(pt, k, 1'b1, 2, r0, r1, 1'b0, 1'b1, 0);
      model_ct = {r0, r1};
      total++;
      if (obs_data.size() !== 6) begin bad++; $display("FAIL rnd_beat_count: got %0d want 6", obs_data.size()); end
      for (int i = 0; i < 6; i++) begin
        total++;
        if (obs_data[i] !== exp_word(pt, k, i)) begin
          bad++; $display("FAIL rnd_beat%0d: got %h want %h", i, obs_data[i], exp_word(pt, k, i));
        end
      end
      total++;
      if (last_mask() !== 6'b100000) begin bad++; $display("FAIL rnd_tlast: got %b want 100000", last_mask()); end
      total++;
      if (viol !== 0) begin bad++; $display("FAIL rnd_stable: got %0d violations want 0", viol); end
      total++;
      if (recv_cyc !== last_m_cyc + 1 || done_cyc !== last_m_cyc + 3) begin
        bad++; $display("FAIL rnd_timing: got recv=%0d done=%0d want %0d/%0d", recv_cyc, done_cyc, last_m_cyc + 1, last_m_cyc + 3);
      end
      total++;
      if (done_ct !== model_ct || done_st !== 2'b00) begin
        bad++; $display("FAIL rnd_result: got %h/%b want %h/00", done_ct, done_st, model_ct);
      end
    end
  endtask

  task automatic test_tlast_error();
    logic [31:0] r0, r1;
    r0 = $urandom; r1 = $urandom;
    run_txn({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 2, r0, r1, 1'b1, 1'b1, 0);
    model_ct = {r0, r1};
    total++;
    if (done_st !== 2'b01) begin bad++; $display("FAIL tlast_err_status: got %b want 01", done_st); end
    total++;
    if (done_ct !== model_ct) begin bad++; $display("FAIL tlast_err_ct: got %h want %h", done_ct, model_ct); end
    r0 = $urandom; r1 = $urandom;
    run_txn({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 2, r0, r1, 1'b0, 1'b0, 0);
    model_ct = {r0, r1};
    total++;
    if (done_st !== 2'b01 || done_ct !== model_ct) begin
      bad++; $display("FAIL tlast_missing: got %b/%h want 01/%h", done_st, done_ct, model_ct);
    end
  endtask

  task automatic test_restart_ignored();
    logic [63:0]  pt;
    logic [127:0] k;
    logic [31:0]  r0, r1;
    pt = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
    r0 = $urandom; r1 = $urandom;
    run_txn(pt, k, 1'b0, 2, r0, r1, 1'b0, 1'b1, 2);
    model_ct = {r0, r1};
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
    total++;
    if (obs_data.size() !== 6) begin bad++; $display("FAIL restart_beat_count: got %0d want 6", obs_data.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (obs_data[i] !== exp_word(pt, k, i)) begin
        bad++; $display("FAIL restart_beat%0d: got %h want %h", i, obs_data[i], exp_word(pt, k, i));
      end
    end
    total++;
    if (done_cyc !== 9 || done_ct !== model_ct) begin
      bad++; $display("FAIL restart_result: got %0d/%h want 9/%h", done_cyc, done_ct, model_ct);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] r0;
    run_txn({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    total++;
    if (done_cyc < 0 || done_cyc !== recv_cyc + 16) begin
      bad++; $display("FAIL timeout_silent_cycle: got %0d want %0d", done_cyc, recv_cyc + 16);
    end
    total++;
    if (done_st !== 2'b10 || done_ct !== model_ct) begin
      bad++; $display("FAIL timeout_silent_result: got %b/%h want 10/%h", done_st, done_ct, model_ct);
    end
    r0 = $urandom;
    run_txn({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1, r0, 32'h0, 1'b1, 1'b0, 0);
    model_ct = {r0, model_ct[31:0]};
    total++;
    if (done_cyc < 0 || done_cyc !== last_s_cyc + 17) begin
      bad++; $display("FAIL timeout_partial_cycle: got %0d want %0d", done_cyc, last_s_cyc + 17);
    end
    total++;
    if (done_st !== 2'b11 || done_ct !== model_ct) begin
      bad++; $display("FAIL timeout_partial_result: got %b/%h want 11/%h", done_st, done_ct, model_ct);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int late_done;
    logic [31:0] r0, r1;
    @(negedge ACLK);
    start = 1'b1; plaintext = {$urandom, $urandom}; key = {$urandom, $urandom, $urandom, $urandom};
    M_AXIS_TREADY = 1'b1;
    @(negedge ACLK); start = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b1; start = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0; start = 1'b0;
    total++;
    if ({M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY, busy, done} !== 5'b0 ||
        M_AXIS_TDATA !== 32'h0 || ciphertext !== 64'h0 || status !== 2'b00) begin
      bad++; $display("FAIL midreset_outputs: got ctl=%b tdata=%h ct=%h st=%b want all 0",
                      {M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY, busy, done}, M_AXIS_TDATA, ciphertext, status);
    end
    late_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge ACLK);
      if (done || busy || M_AXIS_TVALID) late_done++;
    end
    total++;
    if (late_done !== 0) begin bad++; $display("FAIL midreset_idle: got %0d active cycles want 0", late_done); end
    r0 = $urandom; r1 = $urandom;
    run_txn({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 2, r0, r1, 1'b0, 1'b1, 0);
    model_ct = {r0, r1};
    total++;
    if (done_cyc !== 9 || done_ct !== model_ct || done_st !== 2'b00) begin
      bad++; $display("FAIL midreset_recover: got %0d/%h/%b want 9/%h/00", done_cyc, done_ct, done_st, model_ct);
    end
  endtask

  initial begin
    ARESET = 1'b1; start = 1'b0; plaintext = '0; key = '0;
    M_AXIS_TREADY = 1'b0; S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 1'b0;
    test_reset();
    test_basic();
    test_random_ready();
    test_tlast_error();
    test_restart_ignored();
    test_timeout();
    test_reset_mid_transfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prince_axis_master.md
PRINCE_AXIS_MASTER -- requirements
Module: prince_axis_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of cycles spent waiting for response beats; 0 disables the timeout.
REQ-002 SHALL have port ACLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port ARESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: single-cycle request strobe.
REQ-005 SHALL have port plaintext, input, 64 bits: block to encrypt; sampled only when start is accepted.
REQ-006 SHALL have port key, input, 128 bits: cipher key; sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port ciphertext, output, 64 bits: result; holds its value until the next done.
REQ-010 SHALL have port status, output, 2 bits: bit0 = TLAST error, bit1 = timeout; valid with done, held until the next done.
REQ-011 SHALL have ports M_AXIS_TDATA (output, 32 bits), M_AXIS_TVALID (output, 1 bit), M_AXIS_TLAST (output, 1 bit), M_AXIS_TREADY (input, 1 bit): request stream to the cipher core.
REQ-012 SHALL have ports S_AXIS_TDATA (input, 32 bits), S_AXIS_TVALID (input, 1 bit), S_AXIS_TLAST (input, 1 bit), S_AXIS_TREADY (output, 1 bit): response stream from the cipher core.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, RECV, DONE.
REQ-014 SHALL accept start only in IDLE; start in any other state is ignored with no side effects.
REQ-015 On acceptance, SHALL latch plaintext and key, enter SEND, and assert M_AXIS_TVALID on the next cycle.
REQ-016 SHALL send 6 beats in this order: plaintext[63:32], plaintext[31:0], key[127:96], key[95:64], key[63:32], key[31:0].
REQ-017 SHALL assert M_AXIS_TLAST only with beat 6.
REQ-018 SHALL complete a beat only when TVALID and TREADY are both high at a rising edge.
REQ-019 Once TVALID is asserted, SHALL hold TVALID, TDATA and TLAST stable until the handshake completes; back-to-back beats are sent with no bubbles while TREADY stays high.
REQ-020 After the beat-6 handshake, SHALL deassert M_AXIS_TVALID and enter RECV.
REQ-021 In RECV, SHALL drive S_AXIS_TREADY high and hold it low in all other states.
REQ-022 In RECV, SHALL accept exactly 2 beats: beat 1 into ciphertext[63:32], beat 2 into ciphertext[31:0].
REQ-023 SHALL set status bit0 if S_AXIS_TLAST is high on beat 1 or low on beat 2; the 2-beat count still governs completion.
REQ-024 With TIMEOUT_CYCLES nonzero, SHALL count RECV cycles without a handshake (the count resets on each beat).
REQ-025 When that count reaches TIMEOUT_CYCLES, SHALL enter DONE with status bit1 set; the ciphertext bits not received retain their previous values.
REQ-026 DONE SHALL last exactly one cycle, with done high and busy low, then return to IDLE; a start may be accepted the cycle after DONE.
REQ-027 done and busy SHALL be registered; busy is high in SEND and RECV only.
REQ-028 The beat counter SHALL be 3 bits and wrap-free: it clears on every state change and never exceeds 5.
REQ-029 SHALL not add cycles of latency; with both streams always ready, done rises 9 cycles after start acceptance (1 + 6 send + 2 receive).

Reset
REQ-030 ARESET high at a clock edge SHALL force IDLE, clear the counters, and drive M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY, busy and done to 0.
REQ-031 The same ARESET condition SHALL drive M_AXIS_TDATA, ciphertext and status to 0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer immediately with no done pulse; start is ignored while ARESET is high.

Structure
REQ-033 State encodings, beat counts (6 out, 2 in) and status bit indices SHALL live in the shared prince package alongside the cipher constants.
REQ-034 SHALL be a single module with no sub-modules; the timeout counter is inline, with width clog2(TIMEOUT_CYCLES+1).

Verification
REQ-035 Scenario: pt=0x0000000000000000, key=0, both sides always ready, responder returns 0x818665AA, 0x0D02DFDA with TLAST on beat 2 -> ciphertext=0x818665AA0D02DFDA, status=00, done 9 cycles after start.
REQ-036 Scenario: M_AXIS_TREADY randomly toggled at 50% -> 6 beats in the exact REQ-016 order, TDATA stable while stalled, TLAST on beat 6 only.
REQ-037 Scenario: responder drives TLAST on beat 1 -> status=01 and ciphertext still assembled from both beats.
REQ-038 Scenario: TIMEOUT_CYCLES=16, responder silent -> done 16 cycles after RECV entry, status=10.
REQ-039 Scenario: ARESET pulsed during beat 3 of SEND -> next cycle all outputs 0, state IDLE, no done; a new start then completes normally.
REQ-040 Scenario: start re-pulsed while busy -> ignored, latched plaintext and key unchanged, single done.
